// File: rtl/pb_array_pkg.sv
// Shared types and helpers for the push-button debounce/counter array.
// Channel FSM states and the event-selection modes for the counters.
package pb_array_pkg;

  typedef enum logic [1:0] {
    IDLE,
    WAIT_PRESS,
    PRESSED,
    WAIT_RELEASE
  } state_t;

  typedef enum logic [1:0] {
    MODE_PRESS   = 2'd0,
    MODE_RELEASE = 2'd1,
    MODE_BOTH    = 2'd2,
    MODE_LONG    = 2'd3
  } mode_t;

  // Bits needed to hold values 0..n-1, never less than one bit
  function automatic int unsigned width_of(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/pb_channel_fsm.sv
// One button channel: two-flop synchroniser, debounce FSM with tick-driven
// wait timer, long-press timer and single-cycle event pulses.
module pb_channel_fsm
  import pb_array_pkg::*;
#(
  parameter int DELAY_W    = 8,
  parameter int LONG_TICKS = 100
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               pb_in,
  input  logic               tick,
  input  logic [DELAY_W-1:0] delay,
  output logic               pb_level,
  output logic               press_pulse,
  output logic               release_pulse,
  output logic               long_pulse
);

  localparam int LONG_W = width_of(LONG_TICKS + 1);
  localparam logic [LONG_W-1:0] LONG_MAX = LONG_W'(LONG_TICKS);

  logic [1:0]         sync_q;
  logic               sync;
  state_t             state, next_state;
  logic [DELAY_W-1:0] timer, next_timer;
  logic [LONG_W-1:0]  long_cnt, next_long;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[0], pb_in};
    end
  end

  assign sync = sync_q[1];

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state    <= IDLE;
      timer    <= '0;
      long_cnt <= '0;
    end else begin
      state    <= next_state;
      timer    <= next_timer;
      long_cnt <= next_long;
    end
  end

  // Pulses are asserted in the cycle the qualifying transition is taken
  always_comb begin
    next_state    = state;
    next_timer    = timer;
    next_long     = long_cnt;
    pb_level      = 1'b0;
    press_pulse   = 1'b0;
    release_pulse = 1'b0;
    long_pulse    = 1'b0;
    case (state)
      IDLE: begin
        if (sync) begin
          next_timer = delay;
          next_state = WAIT_PRESS;
        end
      end
      WAIT_PRESS: begin
        if (!sync) begin
          next_state = IDLE;
        end else if (timer == '0) begin
          next_state  = PRESSED;
          press_pulse = 1'b1;
          next_long   = '0;
        end else if (tick) begin
          next_timer = timer - DELAY_W'(1);
        end
      end
      PRESSED: begin
        pb_level = 1'b1;
        if (tick && (long_cnt != LONG_MAX)) begin
          next_long  = long_cnt + LONG_W'(1);
          long_pulse = (long_cnt == (LONG_MAX - LONG_W'(1)));
        end
        if (!sync) begin
          next_timer = delay;
          next_state = WAIT_RELEASE;
        end
      end
      WAIT_RELEASE: begin
        pb_level = 1'b1;
        if (sync) begin
          next_state = PRESSED;
        end else if (timer == '0) begin
          next_state    = IDLE;
          release_pulse = 1'b1;
        end else if (tick) begin
          next_timer = timer - DELAY_W'(1);
        end
      end
      default: next_state = IDLE;
    endcase
  end

endmodule

// File: rtl/pb_debounce_counter_array.sv
// Multi-channel push-button front end: shared debounce tick prescaler,
// one debounce FSM per channel and a per-channel event counter.
module pb_debounce_counter_array
  import pb_array_pkg::*;
#(
  parameter int N_CH       = 3,
  parameter int CNT_W      = 8,
  parameter int DELAY_W    = 8,
  parameter int TICK_DIV   = 1000,
  parameter int LONG_TICKS = 100,
  parameter bit SATURATE   = 1'b0
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic [N_CH-1:0]         pb_in,
  input  logic [N_CH*DELAY_W-1:0] delay,
  input  logic [1:0]              count_mode,
  input  logic [N_CH-1:0]         clear,
  output logic [N_CH-1:0]         pb_level,
  output logic [N_CH-1:0]         press_pulse,
  output logic [N_CH-1:0]         release_pulse,
  output logic [N_CH-1:0]         long_pulse,
  output logic [N_CH*CNT_W-1:0]   count
);

  localparam int TICK_W = width_of(TICK_DIV);
  localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(TICK_DIV - 1);

  logic [TICK_W-1:0] tick_cnt;
  logic              tick;
  mode_t             mode;
  logic [N_CH-1:0]   event_hit;

  assign tick = (tick_cnt == TICK_LAST);

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      tick_cnt <= '0;
    end else if (tick) begin
      tick_cnt <= '0;
    end else begin
      tick_cnt <= tick_cnt + TICK_W'(1);
    end
  end

  assign mode = mode_t'(count_mode);

  always_comb begin
    event_hit = '0;
    case (mode)
      MODE_PRESS:   event_hit = press_pulse;
      MODE_RELEASE: event_hit = release_pulse;
      MODE_BOTH:    event_hit = press_pulse | release_pulse;
      MODE_LONG:    event_hit = long_pulse;
      default:      event_hit = '0;
    endcase
  end

  for (genvar g = 0; g < N_CH; g++) begin : g_ch
    logic [CNT_W-1:0] cnt_q;

    pb_channel_fsm #(
      .DELAY_W   (DELAY_W),
      .LONG_TICKS(LONG_TICKS)
    ) u_fsm (
      .clock        (clock),
      .reset        (reset),
      .pb_in        (pb_in[g]),
      .tick         (tick),
      .delay        (delay[g*DELAY_W +: DELAY_W]),
      .pb_level     (pb_level[g]),
      .press_pulse  (press_pulse[g]),
      .release_pulse(release_pulse[g]),
      .long_pulse   (long_pulse[g])
    );

    // Clear wins over a same-cycle event; saturation is a build-time choice
    always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
        cnt_q <= '0;
      end else if (clear[g]) begin
        cnt_q <= '0;
      end else if (event_hit[g]) begin
        if (!(SATURATE && (cnt_q == '1))) begin
          cnt_q <= cnt_q + CNT_W'(1);
        end
      end
    end

    assign count[g*CNT_W +: CNT_W] = cnt_q;
  end

endmodule

// File: tb/tb_pb_debounce_counter_array.sv
// Randomised scoreboard bench for pb_debounce_counter_array: a wrapping and a
// saturating instance share stimulus; expected events are queued per channel.
module tb_pb_debounce_counter_array;
  import pb_array_pkg::*;

  localparam int N_CH       = 3;
  localparam int CNT_W      = 4;
  localparam int DELAY_W    = 8;
  localparam int TICK_DIV   = 4;
  localparam int LONG_TICKS = 3;
  localparam int CNT_MAX    = 15;
  localparam int EV_P       = 1;
  localparam int EV_R       = 2;
  localparam int EV_L       = 4;

  logic                    clock = 1'b0;
  logic                    reset;
  logic [N_CH-1:0]         pb_in;
  logic [N_CH*DELAY_W-1:0] delay;
  logic [1:0]              count_mode;
  logic [N_CH-1:0]         clear;
  logic [N_CH-1:0]         pb_level_w, press_w, rel_w, long_w;
  logic [N_CH-1:0]         pb_level_s, press_s, rel_s, long_s;
  logic [N_CH*CNT_W-1:0]   count_w, count_s;

  int       tests_run = 0;
  int       tests_failed = 0;
  int       exp_q [N_CH][$];
  int       model_w [N_CH];
  int       model_s [N_CH];
  int       cur_mode;
  bit       mon_en;
  logic [2:0] mon_code;

  pb_debounce_counter_array #(
    .N_CH(N_CH), .CNT_W(CNT_W), .DELAY_W(DELAY_W), .TICK_DIV(TICK_DIV),
    .LONG_TICKS(LONG_TICKS), .SATURATE(1'b0)
  ) dut_wrap (
    .clock(clock), .reset(reset), .pb_in(pb_in), .delay(delay),
    .count_mode(count_mode), .clear(clear), .pb_level(pb_level_w),
    .press_pulse(press_w), .release_pulse(rel_w), .long_pulse(long_w),
    .count(count_w)
  );

  pb_debounce_counter_array #(
    .N_CH(N_CH), .CNT_W(CNT_W), .DELAY_W(DELAY_W), .TICK_DIV(TICK_DIV),
    .LONG_TICKS(LONG_TICKS), .SATURATE(1'b1)
  ) dut_sat (
    .clock(clock), .reset(reset), .pb_in(pb_in), .delay(delay),
    .count_mode(count_mode), .clear(clear), .pb_level(pb_level_s),
    .press_pulse(press_s), .release_pulse(rel_s), .long_pulse(long_s),
    .count(count_s)
  );

  always #5 clock = ~clock;

  task automatic check_output(input string name, input int actual, input int expected);
    tests_run++;
    if (actual != expected) begin
      tests_failed++;
      $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
    end
  endtask

  function automatic bit is_counted(input int ev, input int mode);
    case (mode)
      0:       return ev == EV_P;
      1:       return ev == EV_R;
      2:       return (ev == EV_P) || (ev == EV_R);
      default: return ev == EV_L;
    endcase
  endfunction

  function automatic void expect_event(input int ch, input int ev);
    exp_q[ch].push_back(ev);
    if (is_counted(ev, cur_mode)) begin
      model_w[ch] = (model_w[ch] + 1) % (CNT_MAX + 1);
      if (model_s[ch] < CNT_MAX) model_s[ch]++;
    end
  endfunction

  task automatic wait_cycles(input int n);
    repeat (n) @(negedge clock);
  endtask

  // Monitor: every observed pulse must match the oldest queued event
  always @(negedge clock) begin
    if (mon_en && !reset) begin
      for (int ch = 0; ch < N_CH; ch++) begin
        mon_code = {long_w[ch], rel_w[ch], press_w[ch]};
        if (mon_code != 3'b000) begin
          if (exp_q[ch].size() == 0)
            check_output($sformatf("unexpected_pulse_ch%0d", ch), int'(mon_code), 0);
          else
            check_output($sformatf("event_ch%0d", ch), int'(mon_code), exp_q[ch].pop_front());
          if (mon_code == 3'(EV_P))
            check_output($sformatf("level_at_press_ch%0d", ch), int'(pb_level_w[ch]), 0);
          if (mon_code == 3'(EV_R))
            check_output($sformatf("level_at_release_ch%0d", ch), int'(pb_level_w[ch]), 1);
        end
      end
    end
  end

  // Hold lengths keep the long-press outcome independent of tick phase
  task automatic click(input int ch, input int d, input bit lng, input int n_bounce);
    delay[ch*DELAY_W +: DELAY_W] = DELAY_W'(d);
    for (int b = 0; b < n_bounce; b++) begin
      pb_in[ch] = 1'b1;
      wait_cycles($urandom_range(1, 3));
      pb_in[ch] = 1'b0;
      wait_cycles($urandom_range(4, 6));
    end
    expect_event(ch, EV_P);
    if (lng) expect_event(ch, EV_L);
    expect_event(ch, EV_R);
    pb_in[ch] = 1'b1;
    wait_cycles(TICK_DIV * d + (lng ? 14 : 4));
    pb_in[ch] = 1'b0;
    wait_cycles(TICK_DIV * d + 8);
  endtask

  task automatic run_channel(input int ch, input int n);
    for (int i = 0; i < n; i++) begin
      int d;
      bit lng;
      d   = $urandom_range(0, 4);
      lng = 1'($urandom_range(0, 1));
      click(ch, d, lng, (d >= 2) ? $urandom_range(0, 3) : 0);
    end
  endtask

  task automatic check_phase(input string tag);
    for (int ch = 0; ch < N_CH; ch++) begin
      check_output($sformatf("%s_missing_ch%0d", tag, ch), exp_q[ch].size(), 0);
      check_output($sformatf("%s_level_ch%0d", tag, ch), int'(pb_level_w[ch]), 0);
      check_output($sformatf("%s_cnt_wrap_ch%0d", tag, ch),
                   int'(count_w[ch*CNT_W +: CNT_W]), model_w[ch]);
      check_output($sformatf("%s_cnt_sat_ch%0d", tag, ch),
                   int'(count_s[ch*CNT_W +: CNT_W]), model_s[ch]);
    end
  endtask

  task automatic apply_stimulus(input int mode, input string tag);
    int n0, n1, n2;
    count_mode = 2'(mode);
    cur_mode   = mode;
    n0 = $urandom_range(2, 5);
    n1 = $urandom_range(2, 5);
    n2 = $urandom_range(2, 5);
    fork
      run_channel(0, n0);
      run_channel(1, n1);
      run_channel(2, n2);
    join
    wait_cycles(10);
    check_phase(tag);
  endtask

  task automatic check_all_zero(input string tag);
    check_output({tag, "_level"}, int'(pb_level_w | pb_level_s), 0);
    check_output({tag, "_pulses"}, int'(press_w | rel_w | long_w | press_s | rel_s | long_s), 0);
    check_output({tag, "_count_wrap"}, int'(count_w), 0);
    check_output({tag, "_count_sat"}, int'(count_s), 0);
  endtask

  initial begin
    int early;
    reset      = 1'b1;
    pb_in      = '0;
    clear      = '0;
    delay      = '0;
    count_mode = 2'(MODE_PRESS);
    mon_en     = 1'b0;
    cur_mode   = 0;
    for (int ch = 0; ch < N_CH; ch++) begin
      model_w[ch] = 0;
      model_s[ch] = 0;
    end
    wait_cycles(3);
    check_all_zero("reset_state");
    reset  = 1'b0;
    mon_en = 1'b1;
    wait_cycles(2);

    for (int m = 0; m < 4; m++) apply_stimulus(m, $sformatf("mode%0d", m));
    apply_stimulus($urandom_range(0, 3), "mixed");

    // Wrap versus saturate after 17 counted presses
    count_mode = 2'(MODE_PRESS);
    cur_mode   = 0;
    clear      = '1;
    wait_cycles(1);
    clear      = '0;
    for (int ch = 0; ch < N_CH; ch++) begin
      model_w[ch] = 0;
      model_s[ch] = 0;
    end
    check_phase("cleared");
    for (int i = 0; i < 17; i++) click(0, 0, 1'b0, 0);
    wait_cycles(4);
    check_output("wrap_count_ch0", int'(count_w[CNT_W-1:0]), 1);
    check_output("sat_count_ch0", int'(count_s[CNT_W-1:0]), 15);
    check_phase("wrap");

    // Clear lands in the same cycle as the counted press on ch0
    delay[DELAY_W-1:0] = '0;
    exp_q[0].push_back(EV_P);
    exp_q[0].push_back(EV_R);
    pb_in[0] = 1'b1;
    wait_cycles(3);
    check_output("press_latency_delay0", int'(press_w[0]), 1);
    clear[0] = 1'b1;
    wait_cycles(1);
    clear[0] = 1'b0;
    pb_in[0] = 1'b0;
    wait_cycles(8);
    model_w[0] = 0;
    model_s[0] = 0;
    check_phase("clear_vs_inc");
    click(0, 0, 1'b0, 0);
    wait_cycles(4);
    check_phase("after_clear");

    // Asynchronous reset while ch1 is still waiting out its press delay
    count_mode = 2'(MODE_BOTH);
    cur_mode   = 2;
    delay[DELAY_W +: DELAY_W] = DELAY_W'(3);
    pb_in[1] = 1'b1;
    wait_cycles(5);
    reset = 1'b1;
    #1;
    check_all_zero("async_reset");
    for (int ch = 0; ch < N_CH; ch++) begin
      model_w[ch] = 0;
      model_s[ch] = 0;
      exp_q[ch].delete();
    end
    @(negedge clock);
    reset = 1'b0;
    early = 0;
    repeat (11) begin
      @(negedge clock);
      if (press_w[1]) early++;
    end
    check_output("no_early_press_after_reset", early, 0);
    expect_event(1, EV_P);
    expect_event(1, EV_L);
    expect_event(1, EV_R);
    wait_cycles(20);
    pb_in[1] = 1'b0;
    wait_cycles(TICK_DIV * 3 + 8);
    wait_cycles(10);
    check_phase("post_reset");

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
